// File: rtl/painel_scan_controller_pkg.sv
// Shared types and helpers for the panel scan sequencer.
package painel_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/painel_tick_gen.sv
// Modulo-N enable counter; tick marks the enabled cycle that wraps the count.
module painel_tick_gen
  import painel_scan_controller_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/painel_scan_controller.sv
// Panel scan sequencer: one-hot column scan, frame counting and scroll offset,
// all driven by enable ticks on a single clock.
module painel_scan_controller
  import painel_scan_controller_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 32,
  parameter int unsigned NUM_COLS    = 5,
  parameter int unsigned STEP_FRAMES = 64,
  parameter int unsigned MSG_LEN     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       pause,
  input  logic                       dir,
  input  logic                       load,
  input  logic [$clog2(MSG_LEN)-1:0] load_val,
  output logic [NUM_COLS-1:0]        col_sel,
  output logic [$clog2(NUM_COLS)-1:0] col_idx,
  output logic [$clog2(MSG_LEN)-1:0] msg_offset,
  output logic                       scan_tick,
  output logic                       frame_done,
  output logic                       step_tick,
  output logic                       busy
);

  localparam int unsigned CW = $clog2(NUM_COLS);
  localparam int unsigned OW = $clog2(MSG_LEN);
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(MSG_LEN - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_busy;
  logic                  w_run;
  logic                  w_clr;
  logic                  w_scan_tick;
  logic                  w_frame_done;
  logic                  w_frame_en;
  logic                  w_step_tick;
  logic [CW-1:0]         r_col_idx;
  logic [OW-1:0]         r_msg_offset;
  logic [NUM_COLS-1:0]   w_col_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping enable wins over pause from either active state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (enable) w_state_next = RUN;
      RUN: begin
        if (!enable)    w_state_next = IDLE;
        else if (pause) w_state_next = HOLD;
      end
      HOLD: begin
        if (!enable)     w_state_next = IDLE;
        else if (!pause) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_busy = (r_state != IDLE);
  assign w_run  = (r_state == RUN);
  // Clear on the edge into IDLE so the first IDLE cycle already shows zeros.
  assign w_clr  = (w_state_next == IDLE);

  painel_tick_gen #(.N(SCAN_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_busy),
    .tick  (w_scan_tick)
  );

  assign w_frame_done = w_scan_tick && (r_col_idx == COL_LAST);
  assign w_frame_en   = w_frame_done && w_run;

  painel_tick_gen #(.N(STEP_FRAMES)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_frame_en),
    .tick  (w_step_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_idx <= '0;
    end else if (w_clr) begin
      r_col_idx <= '0;
    end else if (w_scan_tick) begin
      r_col_idx <= (r_col_idx == COL_LAST) ? '0 : r_col_idx + CW'(1);
    end
  end

  // A load overrides a coincident step; the step is simply lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msg_offset <= '0;
    end else if (w_clr) begin
      r_msg_offset <= '0;
    end else if (load && w_busy) begin
      r_msg_offset <= load_val;
    end else if (w_step_tick) begin
      if (dir) begin
        r_msg_offset <= (r_msg_offset == '0) ? OFF_LAST : r_msg_offset - OW'(1);
      end else begin
        r_msg_offset <= (r_msg_offset == OFF_LAST) ? '0 : r_msg_offset + OW'(1);
      end
    end
  end

  always_comb begin
    w_col_sel = '0;
    if (w_busy) begin
      w_col_sel = NUM_COLS'(1) << r_col_idx;
    end
  end

  assign col_sel    = w_col_sel;
  assign col_idx    = r_col_idx;
  assign msg_offset = r_msg_offset;
  assign scan_tick  = w_scan_tick;
  assign frame_done = w_frame_done;
  assign step_tick  = w_step_tick;
  assign busy       = w_busy;

endmodule

// File: tb/tb_painel_scan_controller.sv
// Directed bench for painel_scan_controller with SCAN_DIV=4, NUM_COLS=5,
// STEP_FRAMES=2, MSG_LEN=6 (20 cycles per frame, 40 cycles per offset step).
module tb_painel_scan_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pause;
  logic       dir;
  logic       load;
  logic [2:0] load_val;
  logic [4:0] col_sel;
  logic [2:0] col_idx;
  logic [2:0] msg_offset;
  logic       scan_tick;
  logic       frame_done;
  logic       step_tick;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  painel_scan_controller #(
    .SCAN_DIV   (4),
    .NUM_COLS   (5),
    .STEP_FRAMES(2),
    .MSG_LEN    (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pause      (pause),
    .dir        (dir),
    .load       (load),
    .load_val   (load_val),
    .col_sel    (col_sel),
    .col_idx    (col_idx),
    .msg_offset (msg_offset),
    .scan_tick  (scan_tick),
    .frame_done (frame_done),
    .step_tick  (step_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // k = 1 is the first cycle after entering RUN; HOLD does not disturb scanning.
  task automatic check_scan(input int k);
    int idx;
    idx = ((k - 1) / 4) % 5;
    chk("col_sel",    32'(col_sel),    32'(1) << idx);
    chk("col_idx",    32'(col_idx),    32'(idx));
    chk("scan_tick",  32'(scan_tick),  32'((k % 4) == 0));
    chk("frame_done", 32'(frame_done), 32'((k % 20) == 0));
    chk("busy",       32'(busy),       32'(1));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_col_sel"},   32'(col_sel),    32'(0));
    chk({tag, "_col_idx"},   32'(col_idx),    32'(0));
    chk({tag, "_offset"},    32'(msg_offset), 32'(0));
    chk({tag, "_busy"},      32'(busy),       32'(0));
    chk({tag, "_scan_tick"}, 32'(scan_tick),  32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; pause = 1'b0; dir = 1'b0;
    load = 1'b0; load_val = 3'd0;
    #1 reset = 1'b1;
    #1;
    check_idle("reset");
    cyc();
    cyc();
    chk("reset_busy_held", 32'(busy), 32'(0));
    reset = 1'b0;
    enable = 1'b1;

    // Scan order, frame_done, and upward scrolling with wrap 5 -> 0.
    for (int k = 1; k <= 241; k++) begin
      cyc();
      check_scan(k);
      chk("step_up",   32'(step_tick),  32'((k % 40) == 0));
      chk("offset_up", 32'(msg_offset), 32'(((k - 1) / 40) % 6));
    end

    // Downward scrolling with wrap 0 -> 5.
    dir = 1'b1;
    for (int k = 242; k <= 340; k++) begin
      int d;
      cyc();
      check_scan(k);
      d = ((k - 1) / 40) - 6;
      chk("step_dn",   32'(step_tick),  32'((k % 40) == 0));
      chk("offset_dn", 32'(msg_offset), 32'((6 - (d % 6)) % 6));
    end

    // Pause right after a frame: 100 cycles of HOLD, scanning continues.
    pause = 1'b1;
    for (int k = 341; k <= 440; k++) begin
      cyc();
      check_scan(k);
      chk("hold_step",   32'(step_tick),  32'(0));
      chk("hold_offset", 32'(msg_offset), 32'(4));
    end
    pause = 1'b0;
    for (int k = 441; k <= 500; k++) begin
      cyc();
      check_scan(k);
      chk("resume_step",   32'(step_tick),  32'((k == 460) || (k == 500)));
      chk("resume_offset", 32'(msg_offset), 32'((k <= 460) ? 4 : 3));
    end

    // Load coincident with step_tick at cycle 500: load wins.
    load = 1'b1;
    load_val = 3'd3;
    cyc();
    load = 1'b0;
    check_scan(501);
    chk("load_vs_step", 32'(msg_offset), 32'(3));
    for (int k = 502; k <= 525; k++) begin
      cyc();
      check_scan(k);
      chk("post_load_step", 32'(step_tick), 32'(0));
    end

    // Load mid-frame with frame_cnt = 1; next step must still land at 540.
    load = 1'b1;
    load_val = 3'd1;
    cyc();
    load = 1'b0;
    check_scan(526);
    chk("load_midframe", 32'(msg_offset), 32'(1));
    for (int k = 527; k <= 541; k++) begin
      cyc();
      check_scan(k);
      chk("load_keep_cnt_step",   32'(step_tick),  32'(k == 540));
      chk("load_keep_cnt_offset", 32'(msg_offset), 32'((k <= 540) ? 1 : 0));
    end

    load = 1'b1;
    load_val = 3'd5;
    cyc();
    load = 1'b0;
    chk("load5", 32'(msg_offset), 32'(5));

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    check_idle("async_reset");
    #1 enable = 1'b0;
    cyc();
    chk("reset_hold_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    cyc();
    chk("idle_after_reset", 32'(busy), 32'(0));

    // Restart, load an offset, then drop enable together with pause.
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check_scan(k);
    end
    load = 1'b1;
    load_val = 3'd4;
    cyc();
    load = 1'b0;
    check_scan(4);
    chk("restart_load", 32'(msg_offset), 32'(4));
    for (int k = 5; k <= 10; k++) begin
      cyc();
      check_scan(k);
    end
    enable = 1'b0;
    pause = 1'b1;
    cyc();
    check_idle("disable");
    chk("disable_frame_done", 32'(frame_done), 32'(0));
    chk("disable_step_tick",  32'(step_tick),  32'(0));

    // Load while IDLE is ignored.
    load = 1'b1;
    load_val = 3'd3;
    cyc();
    load = 1'b0;
    chk("idle_load_offset", 32'(msg_offset), 32'(0));
    chk("idle_load_busy",   32'(busy),       32'(0));

    // Re-enable: column 0 for four cycles, first scan_tick on the fourth.
    pause = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check_scan(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/painel_scan_controller.md
Name: painel_scan_controller

Overview:
Synchronous sequencer for the panel display. It replaces ripple-divided clocks with single-clock enable ticks. A scan prescaler steps a one-hot column select across the display. Completed frames are counted to advance the message offset, so text scrolls. All logic runs on clk; downstream column drivers and the message ROM consume col_sel and msg_offset directly.

Parameters:
SCAN_DIV, 32, clk cycles per column step (must be >=2)
NUM_COLS, 5, display columns scanned per frame (must be >=2)
STEP_FRAMES, 64, full frames per message-offset step (must be >=1)
MSG_LEN, 16, message length in columns; offset wraps modulo MSG_LEN (must be >=2)

Ports:
clk  input  1  single system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = scan active, 0 = go idle
pause  input  1  level; freezes msg_offset, scanning continues
dir  input  1  scroll direction: 0 = increment offset, 1 = decrement
load  input  1  one-cycle strobe; load msg_offset from load_val
load_val  input  $clog2(MSG_LEN)  offset value to load
col_sel  output  NUM_COLS  one-hot column enable, active high
col_idx  output  $clog2(NUM_COLS)  current column index
msg_offset  output  $clog2(MSG_LEN)  current scroll offset
scan_tick  output  1  one-cycle pulse per column advance
frame_done  output  1  one-cycle pulse when col_idx wraps NUM_COLS-1 -> 0
step_tick  output  1  one-cycle pulse when msg_offset steps
busy  output  1  1 when state != IDLE

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately, with no clock edge.
  - state = IDLE.
  - All counters = 0; msg_offset = 0.
  - All outputs = 0, including col_sel.
- States and transitions:
  - IDLE -> RUN when enable = 1.
  - RUN -> HOLD when pause = 1.
  - HOLD -> RUN when pause = 0.
  - RUN or HOLD -> IDLE when enable = 0. This has priority over pause.
- IDLE:
  - Prescaler, col_idx and frame counter held at 0.
  - msg_offset cleared to 0.
  - col_sel = 0.
  - Ticks low.
- Prescaler (RUN and HOLD): scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - scan_tick = 1 in the cycle scan_cnt == SCAN_DIV-1.
  - col_idx increments on the edge ending that cycle and wraps at NUM_COLS-1.
- col_sel = 1 << col_idx whenever state != IDLE. It is a combinational decode of registered state, so column 0 is selected in the first RUN cycle.
- First scan_tick occurs SCAN_DIV cycles after entering RUN.
- frame_done = scan_tick AND col_idx == NUM_COLS-1.
- Frame counter:
  - Increments on frame_done in RUN only; frozen in HOLD.
  - step_tick = frame_done AND frame_cnt == STEP_FRAMES-1 AND state == RUN; frame_cnt then wraps to 0.
- Offset step on step_tick:
  - dir = 0: msg_offset+1, with MSG_LEN-1 -> 0.
  - dir = 1: msg_offset-1, with 0 -> MSG_LEN-1.
- Load:
  - load is accepted in any non-IDLE state.
  - It overrides a coincident step: the loaded value wins and the step is discarded.
  - It does not reset frame_cnt.
  - load in IDLE is ignored.
- Pause mid-frame: scanning is uninterrupted and frame_cnt is preserved. On resume, counting continues from the preserved value.
- Widths: all counters are unsigned, sized with $clog2, and wrap by explicit compare, never by overflow.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, HOLD};
  - a width function clog2-of-max(1, N).
- One natural sub-module, painel_tick_gen: a parameterized modulo-N enable counter with tick output.
  - Instantiated for the prescaler and the frame counter.
  - Ports: clk, reset, clr, en, tick.

Test Plan (SCAN_DIV=4, NUM_COLS=5, STEP_FRAMES=2, MSG_LEN=6):
1. Release reset, enable=1 -> col_sel 00001 for 4 cycles, then 00010, 00100, 01000, 10000, 00001; frame_done pulses once at cycle 20; busy=1.
2. Run with dir=0 -> step_tick every 40 cycles; msg_offset 0,1,...,5,0. Repeat with dir=1 -> 0,5,4,...
3. Assert pause after 1 frame for 100 cycles -> msg_offset constant and col_sel keeps scanning. Release pause -> next step_tick after exactly 1 more frame (20 cycles of RUN).
4. load=1, load_val=3 in the same cycle as step_tick -> msg_offset=3 next cycle, not 3+/-1. load in IDLE -> offset stays 0.
5. Assert reset between clock edges mid-run -> col_sel, col_idx, msg_offset and busy are 0 before the next clk edge.
6. Drop enable together with pause=1 -> IDLE next edge, col_sel=0, msg_offset=0. Re-enable -> restarts at column 0 with first scan_tick after 4 cycles.
